// File: rtl/branch_history_predictor.sv
// Branch predictor: a table of 2-bit saturating counters plus a pc-relative target adder.
// Define GSHARE_EN to XOR a non-speculative global history into the table index (gshare).
module branch_history_predictor #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PHT_ENTRIES = 64,
    parameter int unsigned GHR_BITS    = 6,
    localparam int unsigned IDX_BITS   = $clog2(PHT_ENTRIES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     pc_next,
    input  logic [XLEN-1:0]     immediate,
    input  logic                jump,
    input  logic                branch,
    output logic [XLEN-1:0]     branch_target,
    output logic                branch_taken,
    output logic [IDX_BITS-1:0] predict_index,
    input  logic                update_valid,
    input  logic [IDX_BITS-1:0] update_index,
    input  logic                update_taken,
    output logic [GHR_BITS-1:0] ghr
);

    logic [IDX_BITS-1:0] base_index;
    logic [1:0]          pht_q [PHT_ENTRIES];
    logic [1:0]          upd_cnt;
    logic [1:0]          upd_next;

    // Word-aligned instructions: the two byte-offset bits carry no information.
    assign base_index    = pc[IDX_BITS+1:2];
    assign branch_target = pc_next + immediate;

    logic unused_pc;
    assign unused_pc = ^{pc[XLEN-1:IDX_BITS+2], pc[1:0]};

`ifdef GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;

    // History advances only on resolved branches, so it never needs repair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
        end else if (update_valid) begin
            ghr_q <= (ghr_q << 1) | GHR_BITS'(update_taken);
        end
    end

    assign ghr           = ghr_q;
    assign predict_index = base_index ^ IDX_BITS'(ghr_q);
`else
    assign ghr           = '0;
    assign predict_index = base_index;
`endif

    always_comb begin
        upd_cnt  = pht_q[update_index];
        upd_next = upd_cnt;
        if (update_taken) begin
            if (upd_cnt != 2'd3) begin
                upd_next = upd_cnt + 2'd1;
            end
        end else begin
            if (upd_cnt != 2'd0) begin
                upd_next = upd_cnt - 2'd1;
            end
        end
    end

    // Same-index read and write in one cycle: the read sees the old counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= 2'd1;
            end
        end else if (update_valid) begin
            pht_q[update_index] <= upd_next;
        end
    end

    always_comb begin
        branch_taken = 1'b0;
        if (jump) begin
            branch_taken = 1'b1;
        end else if (branch) begin
            branch_taken = pht_q[predict_index][1];
        end
    end

endmodule
